alu_rs: RTL

- Reservation station and issue scheduler for the single integer ALU in the out-of-order core.
- Accepts decoded ALU micro-ops from dispatch and holds them until both operands are available.
- Snoops two result broadcast buses (ALU and load/store) to wake up waiting operands.
- Each cycle, issues at most one ready entry to the ALU as a registered calculation request tagged with its ROB index.

---
 rtl/alu_rs.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/alu_rs.sv
// alu_rs: reservation station and issue scheduler for the single integer ALU.
// Holds up to 2**RS_WIDTH decoded micro-ops, wakes operands from the ALU and
// load/store broadcast buses, and issues the lowest-index ready entry each
// cycle as a registered calculation request.

// One station slot: payload, operand tags/values and wakeup logic.
module alu_rs_entry #(
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 rdy_in,
  input  logic                 clear,
  input  logic                 i_wr,
  input  logic                 i_iss,
  input  logic [3:0]           i_op,
  input  logic [31:0]          i_vj,
  input  logic [31:0]          i_vk,
  input  logic                 i_qj_busy,
  input  logic                 i_qk_busy,
  input  logic [ROB_WIDTH-1:0] i_qj,
  input  logic [ROB_WIDTH-1:0] i_qk,
  input  logic [ROB_WIDTH-1:0] i_rob,
  input  logic                 i_alu_valid,
  input  logic [ROB_WIDTH-1:0] i_alu_rob,
  input  logic [31:0]          i_alu_val,
  input  logic                 i_lsb_valid,
  input  logic [ROB_WIDTH-1:0] i_lsb_rob,
  input  logic [31:0]          i_lsb_val,
  output logic                 o_valid,
  output logic                 o_ready,
  output logic [3:0]           o_op,
  output logic [31:0]          o_vj,
  output logic [31:0]          o_vk,
  output logic [ROB_WIDTH-1:0] o_rob
);

  logic                 r_valid;
  logic [3:0]           r_op;
  logic [ROB_WIDTH-1:0] r_rob;
  logic                 r_qj_busy, r_qk_busy;
  logic [ROB_WIDTH-1:0] r_qj, r_qk;
  logic [31:0]          r_vj, r_vk;

  logic                 w_sj_busy, w_sk_busy;
  logic [ROB_WIDTH-1:0] w_sj_q, w_sk_q;
  logic [31:0]          w_sj_v, w_sk_v;
  logic [32:0]          w_j, w_k;

  // Snoop both buses for a pending operand; ALU bus has priority.
  // Returns {busy, value}.
  function automatic logic [32:0] resolve(
    input logic                 busy,
    input logic [ROB_WIDTH-1:0] q,
    input logic [31:0]          v,
    input logic                 av,
    input logic [ROB_WIDTH-1:0] ar,
    input logic [31:0]          aval,
    input logic                 lv,
    input logic [ROB_WIDTH-1:0] lr,
    input logic [31:0]          lval
  );
    if (busy && av && ar == q)      return {1'b0, aval};
    else if (busy && lv && lr == q) return {1'b0, lval};
    else                            return {busy, v};
  endfunction

  // Operand source is the dispatch bus on insert (same-cycle bypass), else stored state.
  always_comb begin
    w_sj_busy = i_wr ? i_qj_busy : r_qj_busy;
    w_sk_busy = i_wr ? i_qk_busy : r_qk_busy;
    w_sj_q    = i_wr ? i_qj      : r_qj;
    w_sk_q    = i_wr ? i_qk      : r_qk;
    w_sj_v    = i_wr ? i_vj      : r_vj;
    w_sk_v    = i_wr ? i_vk      : r_vk;
    w_j = resolve(w_sj_busy, w_sj_q, w_sj_v, i_alu_valid, i_alu_rob, i_alu_val,
                  i_lsb_valid, i_lsb_rob, i_lsb_val);
    w_k = resolve(w_sk_busy, w_sk_q, w_sk_v, i_alu_valid, i_alu_rob, i_alu_val,
                  i_lsb_valid, i_lsb_rob, i_lsb_val);
  end

  // Slot state: flush, insert, issue-free and operand wakeup.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_valid   <= 1'b0;
      r_op      <= '0;
      r_rob     <= '0;
      r_qj_busy <= 1'b0;
      r_qk_busy <= 1'b0;
      r_qj      <= '0;
      r_qk      <= '0;
      r_vj      <= '0;
      r_vk      <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        r_valid <= 1'b0;
      end else begin
        if (i_wr) begin
          r_valid <= 1'b1;
          r_op    <= i_op;
          r_rob   <= i_rob;
          r_qj    <= i_qj;
          r_qk    <= i_qk;
        end else if (i_iss) begin
          r_valid <= 1'b0;
        end
        if (i_wr || r_valid) begin
          r_qj_busy <= w_j[32];
          r_vj      <= w_j[31:0];
          r_qk_busy <= w_k[32];
          r_vk      <= w_k[31:0];
        end
      end
    end
  end

  assign o_valid = r_valid;
  assign o_ready = r_valid & ~r_qj_busy & ~r_qk_busy;
  assign o_op    = r_op;
  assign o_vj    = r_vj;
  assign o_vk    = r_vk;
  assign o_rob   = r_rob;

endmodule

// Top: slot array, free-slot and issue priority encoders, issue register.
module alu_rs #(
  parameter int ROB_WIDTH = 4,
  parameter int RS_WIDTH  = 3
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 rdy_in,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [3:0]           in_op,
  input  logic [31:0]          in_vj,
  input  logic [31:0]          in_vk,
  input  logic                 in_qj_busy,
  input  logic                 in_qk_busy,
  input  logic [ROB_WIDTH-1:0] in_qj,
  input  logic [ROB_WIDTH-1:0] in_qk,
  input  logic [ROB_WIDTH-1:0] in_rob,
  output logic                 full,
  input  logic                 cdb_alu_valid,
  input  logic                 cdb_lsb_valid,
  input  logic [ROB_WIDTH-1:0] cdb_alu_rob,
  input  logic [ROB_WIDTH-1:0] cdb_lsb_rob,
  input  logic [31:0]          cdb_alu_val,
  input  logic [31:0]          cdb_lsb_val,
  output logic                 cal,
  output logic [31:0]          a,
  output logic [31:0]          b,
  output logic [3:0]           alu_op,
  output logic [ROB_WIDTH-1:0] cal_rob
);

  localparam int RS_SIZE = 2 ** RS_WIDTH;

  logic [RS_SIZE-1:0]                w_valid, w_ready, w_wr, w_iss;
  logic [RS_SIZE-1:0][3:0]           w_op;
  logic [RS_SIZE-1:0][31:0]          w_vj, w_vk;
  logic [RS_SIZE-1:0][ROB_WIDTH-1:0] w_rob;
  logic [RS_WIDTH-1:0]               w_free_idx, w_iss_idx;
  logic                              w_ins, w_iss_any;

  // full is taken from the current valid bits, before any same-cycle issue.
  assign full      = &w_valid;
  assign w_ins     = in_valid & ~full & ~clear;
  assign w_iss_any = (|w_ready) & ~clear;

  // Lowest-index free slot and lowest-index ready slot, independently.
  always_comb begin
    w_free_idx = '0;
    w_iss_idx  = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!w_valid[i]) w_free_idx = RS_WIDTH'(i);
      if (w_ready[i])  w_iss_idx  = RS_WIDTH'(i);
    end
  end

  for (genvar g = 0; g < RS_SIZE; g++) begin : g_ent
    assign w_wr[g]  = w_ins     && (w_free_idx == RS_WIDTH'(g));
    assign w_iss[g] = w_iss_any && (w_iss_idx  == RS_WIDTH'(g));

    alu_rs_entry #(.ROB_WIDTH(ROB_WIDTH)) u_ent (
      .clk_in      (clk_in),
      .rst_n_in    (rst_n_in),
      .rdy_in      (rdy_in),
      .clear       (clear),
      .i_wr        (w_wr[g]),
      .i_iss       (w_iss[g]),
      .i_op        (in_op),
      .i_vj        (in_vj),
      .i_vk        (in_vk),
      .i_qj_busy   (in_qj_busy),
      .i_qk_busy   (in_qk_busy),
      .i_qj        (in_qj),
      .i_qk        (in_qk),
      .i_rob       (in_rob),
      .i_alu_valid (cdb_alu_valid),
      .i_alu_rob   (cdb_alu_rob),
      .i_alu_val   (cdb_alu_val),
      .i_lsb_valid (cdb_lsb_valid),
      .i_lsb_rob   (cdb_lsb_rob),
      .i_lsb_val   (cdb_lsb_val),
      .o_valid     (w_valid[g]),
      .o_ready     (w_ready[g]),
      .o_op        (w_op[g]),
      .o_vj        (w_vj[g]),
      .o_vk        (w_vk[g]),
      .o_rob       (w_rob[g])
    );
  end

  // Issue register: operands/op/tag hold when nothing issues, only cal drops.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cal     <= 1'b0;
      a       <= '0;
      b       <= '0;
      alu_op  <= '0;
      cal_rob <= '0;
    end else if (rdy_in) begin
      if (w_iss_any) begin
        cal     <= 1'b1;
        a       <= w_vj[w_iss_idx];
        b       <= w_vk[w_iss_idx];
        alu_op  <= w_op[w_iss_idx];
        cal_rob <= w_rob[w_iss_idx];
      end else begin
        cal <= 1'b0;
      end
    end
  end

endmodule
